reg_serializer: RTL and testbench
=================================

# reg_serializer

Serial register encoder: the transmit end of the nibble-framed UART link that drives the `uart` register decoder (APU registers $4000–$4003). Host-side writes land in four 8-bit shadow registers. Each written register is sent as two 8N1 frames at one bit per BAUD_DIV clocks: low nibble first, then high nibble. The block sits upstream of the serial pin and shares the same 5x-baud clock domain as the decoder.

## Interface
- BAUD_DIV, 5, clocks per bit cell; must match the decoder's division.
- GAP_BITS, 1, extra idle (mark) bit cells appended after every stop bit; legal range 0–7.
- clk  input  1  5x baud clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write strobe, sampled on rising clk
- wr_addr  input  2  register index 0–3 ($4000–$4003)
- wr_data  input  8  register value
- tx  output  1  serial line, idle high
- busy  output  1  high while a frame pair is in flight
- pending  output  4  bit k set = register k written and not yet loaded for transmission

## Operation
- Frame layout on tx, LSB first: start(0), d0..d7, stop(1), then GAP_BITS idle(1).
  - d[3:0] = nibble.
  - d[6:4] = wire address.
  - d7 = 0.
- Register k is sent as two frames:
  - First: wire address 2k carrying wr_data[3:0].
  - Second: wire address 2k+1 carrying wr_data[7:4].
- Write: on wr_en, shadow[wr_addr] <= wr_data and pending[wr_addr] <= 1. Writes are always accepted; there is no backpressure. Repeated writes before transmission coalesce, and the last value wins.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE: tx=1, busy=0. If pending≠0, select lowest set index k. Load tx_buf <= shadow[k], clear pending[k], set half=0, go to START.
  - START: tx=0 for BAUD_DIV clocks, then DATA with bit index 0.
  - DATA: tx=d[bit] for BAUD_DIV clocks per bit. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV clocks. Then go to GAP if GAP_BITS>0; otherwise go straight to the frame-end decision.
  - GAP: tx=1 for GAP_BITS*BAUD_DIV clocks, then frame-end decision.
  - Frame-end decision: if half=0, set half=1 and go to START (high-nibble frame). If half=1, go to IDLE.
- Priority: lowest index first. Register 3 ($4003, which triggers the decoder's reg_change) is therefore sent after any simultaneously pending lower registers.
- Simultaneous write and load of the same index k in the IDLE cycle:
  - tx_buf takes the pre-write shadow value.
  - pending[k] stays 1 (the write wins over the clear).
  - The new value is sent in a later pair.
- Write during transmission: updates the shadow and pending only. tx_buf is never modified mid-pair.
- Bit-cell counter width is ceil(log2(BAUD_DIV)). The gap counter covers GAP_BITS*BAUD_DIV−1 with no wrap.

## Timing
- Reset values:
  - tx=1, busy=0, pending=0.
  - All shadows 0, tx_buf 0, state IDLE, counters 0.
- Reset is asynchronous and may arrive mid-frame. tx returns high immediately and in-flight data is discarded. The decoder resynchronizes from the idle pattern.
- Latency from a write sampled at edge N while the block is IDLE:
  - pending[k] rises after N.
  - Load occurs at N+1; busy rises and tx falls after N+1.
- Frame length is (10+GAP_BITS)*BAUD_DIV clocks: 55 with defaults. Pair length: 110.
- busy stays high for the entire pair with no gap between the two frames. busy falls on the edge that re-enters IDLE.
- Back-to-back pairs: if pending≠0 on IDLE entry, the next load happens on the following edge. This inserts exactly one extra idle clock between pairs.
- All outputs are registered, so tx has no glitches.

## Test plan
- Reset then idle for 200 clocks -> tx=1, busy=0, pending=0 throughout.
- Write reg0=0xA5 -> tx falls 2 edges later, sending bytes 0x05 then 0x1A. Each bit is 5 clocks, followed by 10 idle clocks per frame. busy is high for 110 clocks. A decoder model reports $4000=0xA5.
- Write reg3=0x3C and reg1=0x0F in the same idle window -> reg1 pair (0x2F, 0x30) is sent first, then reg3 pair (0x6C, 0x73). The decoder's reg_change toggles exactly once, after $4001 is already updated.
- Write reg2=0x11 then reg2=0x22 during an unrelated pair -> only 0x22 is transmitted for reg2; pending[2] clears at load.
- Write reg0=0x99 in the exact cycle the FSM loads reg0 (old value 0x44) -> 0x44 is transmitted first. pending[0] remains set, and a second pair carries 0x99.
- Assert rst during the DATA state of the high-nibble frame -> tx=1 asynchronously, pending=0. A subsequent write reg1=0x5A is decoded correctly as $4001=0x5A.

Source files
------------

// File: rtl/reg_serializer_if.sv
// Host-side write bus for the register serializer: one strobe and
// an address/data pair. The strobe is sampled on the serializer's clock.
interface reg_serializer_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/reg_serializer.sv
// Serial register encoder: shadows four APU registers and sends each written
// one as two nibble-carrying 8N1 frames (low nibble first) on a registered tx.
module reg_serializer #(
  parameter int BAUD_DIV = 5,
  parameter int GAP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_serializer_if.slave        wr,
  output logic                   tx,
  output logic                   busy,
  output logic [3:0]             pending
);

  localparam int CNT_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int GAP_LEN = GAP_BITS * BAUD_DIV;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             half_q, half_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       buf_q, buf_d;
  logic [3:0]       pending_q, pending_d;
  logic [7:0]       shadow_q [4];
  logic             tx_q, tx_d;
  logic             busy_q;

  logic             cell_end;
  logic             frame_done;
  logic [1:0]       sel;
  logic [7:0]       frame_byte;

  assign cell_end = (cnt_q == CELL_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    half_d     = half_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    pending_d  = pending_q;
    frame_done = 1'b0;
    sel        = 2'd0;
    frame_byte = 8'h00;
    tx_d       = 1'b1;

    // Lowest pending index wins, so $4003 always follows its siblings.
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) sel = 2'(i);
    end

    unique case (state_q)
      S_IDLE: begin
        if (pending_q != 4'd0) begin
          buf_d          = shadow_q[sel];
          idx_d          = sel;
          pending_d[sel] = 1'b0;
          half_d         = 1'b0;
          cnt_d          = '0;
          state_d        = S_START;
        end
      end
      S_START: begin
        if (cell_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cell_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cell_end) begin
          cnt_d = '0;
          if (GAP_BITS > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            frame_done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d      = '0;
          frame_done = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
      if (!half_q) begin
        half_d  = 1'b1;
        state_d = S_START;
      end else begin
        state_d = S_IDLE;
      end
    end

    // A write applied after the load clear keeps the bit set when both hit k.
    if (wr.wr_en) pending_d[wr.wr_addr] = 1'b1;

    frame_byte = {1'b0, idx_d, half_d, (half_d ? buf_d[7:4] : buf_d[3:0])};
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = frame_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      gap_q     <= '0;
      half_q    <= 1'b0;
      idx_q     <= 2'd0;
      buf_q     <= 8'h00;
      pending_q <= 4'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      half_q    <= half_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // NOTE: the shadow file is small and its power-up contents are
  // architecturally visible, so it is reset like ordinary flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '{default: 8'h00};
    end else if (wr.wr_en) begin
      shadow_q[wr.wr_addr] <= wr.wr_data;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: receives frames from tx at mid-bit,
// feeds a nibble decoder model and compares against hand-computed bytes.
module tb_reg_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       busy;
  logic [3:0] pending;

  always #5 clk = ~clk;

  reg_serializer_if bus ();

  reg_serializer #(.BAUD_DIV(5), .GAP_BITS(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (bus),
    .tx      (tx),
    .busy    (busy),
    .pending (pending)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         t_load;
  logic [7:0] b;
  logic [7:0] dec [4];
  int         chg_cnt;
  logic [7:0] chg_reg1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Decoder model: even wire address fills the low nibble, odd the high one;
  // the $4003 high nibble raises reg_change.
  task automatic decode(input logic [7:0] f);
    if (f[4]) dec[f[6:5]][7:4] = f[3:0];
    else      dec[f[6:5]][3:0] = f[3:0];
    if (f[6:4] == 3'd7) begin
      chg_cnt++;
      chg_reg1 = dec[1];
    end
  endtask

  // Finds a start bit, then samples each cell in its middle.
  task automatic get_frame(input string tag, output logic [7:0] f);
    int budget = 2000;
    f = 8'hxx;
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed no start bit expected one within 2000 clocks", tag);
      return;
    end
    repeat (2) @(negedge clk);
    check({tag, "_start"}, 32'(tx), 32'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (5) @(negedge clk);
      f[i] = tx;
    end
    repeat (5) @(negedge clk);
    check({tag, "_stop"}, 32'(tx), 32'h1);
    decode(f);
  endtask

  task automatic wait_idle(input string tag);
    int budget = 2000;
    while (busy === 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed busy stuck high expected idle within 2000 clocks", tag);
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 8'h00;
    chg_cnt     = 0;
    chg_reg1    = 8'h00;
    for (int i = 0; i < 4; i++) dec[i] = 8'h00;

    // Reset and a long idle stretch.
    repeat (3) @(negedge clk);
    check("rst_out", {26'd0, tx, busy, pending}, 32'h20);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_out", {26'd0, tx, busy, pending}, 32'h20);
    end

    // reg0 = 0xA5: latency, frame contents, pair length.
    write_reg(2'd0, 8'hA5);
    check("a5_pend", 32'(pending), 32'h1);
    check("a5_pre_tx", 32'(tx), 32'h1);
    check("a5_pre_busy", 32'(busy), 32'h0);
    @(negedge clk);
    t_load = cyc;
    check("a5_load_tx", 32'(tx), 32'h0);
    check("a5_load_busy", 32'(busy), 32'h1);
    check("a5_load_pend", 32'(pending), 32'h0);
    get_frame("a5_lo", b);
    check("a5_lo", 32'(b), 32'h05);
    get_frame("a5_hi", b);
    check("a5_hi", 32'(b), 32'h1A);
    // reg3 and reg1 queued together while the pair finishes.
    write_reg(2'd3, 8'h3C);
    write_reg(2'd1, 8'h0F);
    wait_idle("a5_idle");
    check("a5_busy_len", 32'(cyc - t_load), 32'd110);
    check("q_pend", 32'(pending), 32'hA);
    check("dec_4000", 32'(dec[0]), 32'hA5);

    // Priority: reg1 first after one idle clock, then reg3.
    @(negedge clk);
    check("r1_load_busy", 32'(busy), 32'h1);
    check("r1_load_pend", 32'(pending), 32'h8);
    get_frame("r1_lo", b);
    check("r1_lo", 32'(b), 32'h2F);
    get_frame("r1_hi", b);
    check("r1_hi", 32'(b), 32'h30);
    wait_idle("r1_idle");
    check("r3_wait_pend", 32'(pending), 32'h8);
    @(negedge clk);
    check("r3_load_busy", 32'(busy), 32'h1);
    check("r3_load_pend", 32'(pending), 32'h0);
    get_frame("r3_lo", b);
    check("r3_lo", 32'(b), 32'h6C);
    get_frame("r3_hi", b);
    check("r3_hi", 32'(b), 32'h73);
    wait_idle("r3_idle");
    check("dec_4001", 32'(dec[1]), 32'h0F);
    check("dec_4003", 32'(dec[3]), 32'h3C);
    check("chg_cnt", 32'(chg_cnt), 32'd1);
    check("chg_after_4001", 32'(chg_reg1), 32'h0F);

    // Coalescing: reg2 written twice during an unrelated reg0 pair.
    write_reg(2'd0, 8'h5C);
    write_reg(2'd2, 8'h11);
    write_reg(2'd2, 8'h22);
    check("co_pend", 32'(pending), 32'h4);
    check("co_busy", 32'(busy), 32'h1);
    get_frame("5c_lo", b);
    check("5c_lo", 32'(b), 32'h0C);
    get_frame("5c_hi", b);
    check("5c_hi", 32'(b), 32'h15);
    wait_idle("5c_idle");
    @(negedge clk);
    check("r2_load_pend", 32'(pending), 32'h0);
    get_frame("r2_lo", b);
    check("r2_lo", 32'(b), 32'h42);
    get_frame("r2_hi", b);
    check("r2_hi", 32'(b), 32'h52);
    wait_idle("r2_idle");
    check("dec_4002", 32'(dec[2]), 32'h22);

    // Write to reg0 in the very cycle reg0 is loaded.
    write_reg(2'd1, 8'h12);
    write_reg(2'd0, 8'h44);
    check("hz_pre_pend", 32'(pending), 32'h1);
    get_frame("12_lo", b);
    check("12_lo", 32'(b), 32'h22);
    get_frame("12_hi", b);
    check("12_hi", 32'(b), 32'h31);
    wait_idle("12_idle");
    write_reg(2'd0, 8'h99);
    check("hz_busy", 32'(busy), 32'h1);
    check("hz_pend", 32'(pending), 32'h1);
    get_frame("44_lo", b);
    check("44_lo", 32'(b), 32'h04);
    get_frame("44_hi", b);
    check("44_hi", 32'(b), 32'h14);
    check("dec_4000_old", 32'(dec[0]), 32'h44);
    wait_idle("44_idle");
    check("hz_repend", 32'(pending), 32'h1);
    @(negedge clk);
    check("99_load_busy", 32'(busy), 32'h1);
    check("99_load_pend", 32'(pending), 32'h0);
    get_frame("99_lo", b);
    check("99_lo", 32'(b), 32'h09);
    get_frame("99_hi", b);
    check("99_hi", 32'(b), 32'h19);
    wait_idle("99_idle");
    check("dec_4000_new", 32'(dec[0]), 32'h99);

    // Asynchronous reset in the DATA phase of a high-nibble frame.
    write_reg(2'd3, 8'hAB);
    write_reg(2'd0, 8'h01);
    get_frame("ab_lo", b);
    check("ab_lo", 32'(b), 32'h6B);
    for (int i = 0; i < 2000 && tx !== 1'b0; i++) @(negedge clk);
    check("ab_hi_start", 32'(tx), 32'h0);
    repeat (12) @(negedge clk);
    check("ar_pre_busy", 32'(busy), 32'h1);
    check("ar_pre_pend", 32'(pending), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_tx", 32'(tx), 32'h1);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_pend", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    write_reg(2'd1, 8'h5A);
    get_frame("5a_lo", b);
    check("5a_lo", 32'(b), 32'h2A);
    get_frame("5a_hi", b);
    check("5a_hi", 32'(b), 32'h35);
    wait_idle("5a_idle");
    check("dec_4001_rst", 32'(dec[1]), 32'h5A);
    check("post_rst_pend", 32'(pending), 32'h0);
    check("post_rst_tx", 32'(tx), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
